// File: rtl/tiny16_pkg.sv
// Shared constants and types for the tiny16 instruction sequencer: opcodes,
// mux/ALU codes, FSM state encoding and instruction field positions.
package tiny16_pkg;

   localparam int OPC_LSB = 12;
   localparam int DST_LSB = 9;
   localparam int SRC_LSB = 6;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_MOV = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_LDI = 4'h7;
   localparam logic [3:0] OP_LD  = 4'h8;
   localparam logic [3:0] OP_ST  = 4'h9;
   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_JZ  = 4'hB;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;

   localparam logic [1:0] IN_SEL_ALU = 2'd0;
   localparam logic [1:0] IN_SEL_SRC = 2'd1;
   localparam logic [1:0] IN_SEL_MEM = 2'd2;

   localparam logic [1:0] ADDR_SEL_PC  = 2'd0;
   localparam logic [1:0] ADDR_SEL_SRC = 2'd1;
   localparam logic [1:0] ADDR_SEL_DST = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_HALT   = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      CLS_NOP, CLS_ALU, CLS_MOV, CLS_JMP, CLS_JZ, CLS_MEM, CLS_HLT, CLS_ILL
   } cls_e;

   typedef enum logic [1:0] {
      MK_NONE, MK_LDI, MK_LD, MK_ST
   } mem_kind_e;

   typedef struct packed {
      cls_e       cls;
      logic [2:0] alu_op;
      mem_kind_e  mem_kind;
   } decode_t;

   // Registered control word; the *_on_ack / wr_on_zero bits arm strobes that
   // fire in the cycle their qualifying input arrives.
   typedef struct packed {
      logic [2:0] src_sel;
      logic [2:0] dst_sel;
      logic [1:0] in_sel;
      logic [2:0] alu_op;
      logic [1:0] addr_sel;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_out_en;
      logic       wr_en;
      logic       wr_on_ack;
      logic       wr_on_zero;
      logic       inc_on_ack;
      logic       halted;
      logic       illegal;
   } ctl_t;

   function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
      return ir[OPC_LSB +: 4];
   endfunction

   function automatic logic [2:0] ir_dst(input logic [15:0] ir);
      return ir[DST_LSB +: 3];
   endfunction

   function automatic logic [2:0] ir_src(input logic [15:0] ir);
      return ir[SRC_LSB +: 3];
   endfunction

endpackage

// File: rtl/tiny16_if.sv
// Register-file and memory handshake bundle between the tiny16 sequencer
// (master) and the datapath/memory side (slave).
interface tiny16_if #(
   parameter int WIDTH = 16,
   parameter int SEL_W = 3
);
   logic [WIDTH-1:0] instr;
   logic             mem_ack;
   logic             zero;
   logic [SEL_W-1:0] src_sel;
   logic [SEL_W-1:0] dst_sel;
   logic             reg_in_en;
   logic             reg_out_en;
   logic             pc_inc;
   logic [1:0]       in_sel;
   logic [2:0]       alu_op;
   logic [1:0]       addr_sel;
   logic             mem_rd;
   logic             mem_wr;

   modport master (
      input  instr, mem_ack, zero,
      output src_sel, dst_sel, reg_in_en, reg_out_en, pc_inc,
             in_sel, alu_op, addr_sel, mem_rd, mem_wr
   );

   modport slave (
      output instr, mem_ack, zero,
      input  src_sel, dst_sel, reg_in_en, reg_out_en, pc_inc,
             in_sel, alu_op, addr_sel, mem_rd, mem_wr
   );
endinterface

// File: rtl/tiny16_decoder.sv
// Combinational opcode classifier: instruction class, ALU operation and
// memory access kind for the sequencer.
module tiny16_decoder
   import tiny16_pkg::*;
(
   input  logic [3:0] opcode,
   output decode_t    dec
);

   always_comb begin
      dec.cls      = CLS_ILL;
      dec.alu_op   = ALU_ADD;
      dec.mem_kind = MK_NONE;
      case (opcode)
         OP_NOP: dec.cls = CLS_NOP;
         OP_MOV: dec.cls = CLS_MOV;
         OP_ADD: begin
            dec.cls    = CLS_ALU;
            dec.alu_op = ALU_ADD;
         end
         OP_SUB: begin
            dec.cls    = CLS_ALU;
            dec.alu_op = ALU_SUB;
         end
         OP_AND: begin
            dec.cls    = CLS_ALU;
            dec.alu_op = ALU_AND;
         end
         OP_OR: begin
            dec.cls    = CLS_ALU;
            dec.alu_op = ALU_OR;
         end
         OP_XOR: begin
            dec.cls    = CLS_ALU;
            dec.alu_op = ALU_XOR;
         end
         OP_LDI: begin
            dec.cls      = CLS_MEM;
            dec.mem_kind = MK_LDI;
         end
         OP_LD: begin
            dec.cls      = CLS_MEM;
            dec.mem_kind = MK_LD;
         end
         OP_ST: begin
            dec.cls      = CLS_MEM;
            dec.mem_kind = MK_ST;
         end
         OP_JMP: dec.cls = CLS_JMP;
         OP_JZ:  dec.cls = CLS_JZ;
         OP_HLT: dec.cls = CLS_HLT;
         default: dec.cls = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/tiny16_control.sv
// tiny16 instruction sequencer: fetch/decode/execute FSM driving the register
// file selects and the memory read/write handshake.
module tiny16_control
   import tiny16_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEL_W = 3
) (
   input  logic       clk,
   input  logic       rst,
   tiny16_if.master   bus,
   output logic       halted,
   output logic       illegal
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   ctl_t             ctl_q, ctl_d;
   decode_t          dec;
   logic             fetch_ack;
   logic             mem_done;

   // Decoding ir_d lets DECODE-cycle outputs be registered from the fetched word.
   tiny16_decoder u_decoder (
      .opcode (ir_opcode(ir_d)),
      .dec    (dec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         ctl_q   <= ctl_d;
      end
   end

   always_comb begin
      fetch_ack = (state_q == S_FETCH) && ctl_q.mem_rd && bus.mem_ack;
      mem_done  = (state_q == S_MEM) && (ctl_q.mem_rd || ctl_q.mem_wr) && bus.mem_ack;
      ir_d      = fetch_ack ? bus.instr : ir_q;
      state_d   = state_q;
      case (state_q)
         S_FETCH:  if (fetch_ack) state_d = S_DECODE;
         S_DECODE: begin
            case (dec.cls)
               CLS_HLT:          state_d = S_HALT;
               CLS_NOP, CLS_ILL: state_d = S_FETCH;
               default:          state_d = S_EXEC;
            endcase
         end
         S_EXEC:   state_d = (dec.cls == CLS_MEM) ? S_MEM : S_FETCH;
         S_MEM:    if (mem_done) state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      ctl_d = '0;
      case (state_d)
         S_FETCH: begin
            // After a data access completes, drop the request for one cycle
            // so the instruction read is seen as a new transaction.
            ctl_d.mem_rd     = !mem_done;
            ctl_d.inc_on_ack = !mem_done;
            ctl_d.addr_sel   = ADDR_SEL_PC;
         end
         S_DECODE: begin
            ctl_d.src_sel = ir_src(ir_d);
            ctl_d.dst_sel = ir_dst(ir_d);
            ctl_d.illegal = (dec.cls == CLS_ILL);
         end
         S_EXEC: begin
            ctl_d.src_sel = ir_src(ir_d);
            ctl_d.dst_sel = ir_dst(ir_d);
            case (dec.cls)
               CLS_ALU: begin
                  ctl_d.alu_op = dec.alu_op;
                  ctl_d.in_sel = IN_SEL_ALU;
                  ctl_d.wr_en  = 1'b1;
               end
               CLS_MOV: begin
                  ctl_d.in_sel = IN_SEL_SRC;
                  ctl_d.wr_en  = 1'b1;
               end
               CLS_JMP: begin
                  ctl_d.dst_sel = 3'd0;
                  ctl_d.in_sel  = IN_SEL_SRC;
                  ctl_d.wr_en   = 1'b1;
               end
               CLS_JZ: begin
                  ctl_d.dst_sel    = 3'd0;
                  ctl_d.in_sel     = IN_SEL_SRC;
                  ctl_d.wr_on_zero = 1'b1;
               end
               CLS_MEM: begin
                  case (dec.mem_kind)
                     MK_LD:   ctl_d.addr_sel = ADDR_SEL_SRC;
                     MK_ST:   ctl_d.addr_sel = ADDR_SEL_DST;
                     default: ctl_d.addr_sel = ADDR_SEL_PC;
                  endcase
               end
               default: ;
            endcase
         end
         S_MEM: begin
            ctl_d.src_sel = ir_src(ir_d);
            ctl_d.dst_sel = ir_dst(ir_d);
            case (dec.mem_kind)
               MK_LDI: begin
                  ctl_d.addr_sel   = ADDR_SEL_PC;
                  ctl_d.mem_rd     = 1'b1;
                  ctl_d.in_sel     = IN_SEL_MEM;
                  ctl_d.wr_on_ack  = 1'b1;
                  // An LDI into r0 is itself the PC write, so it must not also increment.
                  ctl_d.inc_on_ack = (ir_dst(ir_d) != 3'd0);
               end
               MK_LD: begin
                  ctl_d.addr_sel  = ADDR_SEL_SRC;
                  ctl_d.mem_rd    = 1'b1;
                  ctl_d.in_sel    = IN_SEL_MEM;
                  ctl_d.wr_on_ack = 1'b1;
               end
               MK_ST: begin
                  ctl_d.addr_sel   = ADDR_SEL_DST;
                  ctl_d.reg_out_en = 1'b1;
                  ctl_d.mem_wr     = 1'b1;
               end
               default: ;
            endcase
         end
         S_HALT:  ctl_d.halted = 1'b1;
         default: ;
      endcase
   end

   // Ack- and zero-qualified strobes must land in the cycle the data/flag is valid.
   assign bus.pc_inc     = ctl_q.inc_on_ack & ctl_q.mem_rd & bus.mem_ack;
   assign bus.reg_in_en  = ctl_q.wr_en
                         | (ctl_q.wr_on_ack & ctl_q.mem_rd & bus.mem_ack)
                         | (ctl_q.wr_on_zero & bus.zero);
   assign bus.src_sel    = SEL_W'(ctl_q.src_sel);
   assign bus.dst_sel    = SEL_W'(ctl_q.dst_sel);
   assign bus.reg_out_en = ctl_q.reg_out_en;
   assign bus.in_sel     = ctl_q.in_sel;
   assign bus.alu_op     = ctl_q.alu_op;
   assign bus.addr_sel   = ctl_q.addr_sel;
   assign bus.mem_rd     = ctl_q.mem_rd;
   assign bus.mem_wr     = ctl_q.mem_wr;
   assign halted         = ctl_q.halted;
   assign illegal        = ctl_q.illegal;

endmodule
